exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
- Multi-cycle execute engine for the calculator: performs operand A (op) operand B when the control FSM issues its execute pulse.
- Add and subtract complete in one cycle. Multiply runs as iterative shift-add, divide as restoring division, one bit per cycle.
- Holds result and error flags for the result display until the next accepted execute.
- Sits between the control FSM (execute, op code, abort) and the operand registers and display mux.

Parameters:
- WIDTH, 16, operand/result width in bits (unsigned binary, >= 4).
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- start  in  1  execute request pulse from control FSM; accepted only in IDLE.
- abort  in  1  clear request; cancels an in-flight operation.
- op  in  2  operation, sampled on accept: 0 add, 1 sub, 2 mul, 3 div.
- operand_a  in  WIDTH  first operand, sampled on accept.
- operand_b  in  WIDTH  second operand, sampled on accept.
- result  out  WIDTH  registered result.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a result is written.
- err_ovf  out  1  overflow/borrow flag for the current result.
- err_div0  out  1  divide-by-zero flag for the current result.

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, internal regs=0; result=0, busy=0, done=0, err_ovf=0, err_div0=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - On start=1 (abort=0), latch op and operands, then branch by operation:
  - add: result=A+B mod 2^WIDTH; err_ovf=carry-out; err_div0=0; go to DONE.
  - sub: result=A-B mod 2^WIDTH; err_ovf=(A<B); err_div0=0; go to DONE.
  - div with B=0: result=all ones; err_div0=1; err_ovf=0; go to DONE.
  - mul, or div with B!=0: clear accumulator; counter=WIDTH; go to CALC.
- CALC:
  - One iteration per cycle; counter decrements per cycle.
  - mul: 2*WIDTH-bit accumulator, LSB-first shift-add.
  - div: restoring division, MSB-first, WIDTH-bit partial remainder.
  - When counter reaches 1, the final iteration executes and the block writes result and flags, then goes to DONE.
  - mul: result = low WIDTH bits of product; err_ovf=1 iff upper WIDTH bits are nonzero.
  - div: result = quotient; err_ovf=0.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- Latency, start edge to done high:
  - add/sub/div0: 1 cycle.
  - mul/div: WIDTH+1 cycles.
- Handshake:
  - start in CALC or DONE is ignored; it is not queued.
  - start and done are never acknowledged by the same cycle's logic.
- abort:
  - In CALC or DONE: go to IDLE next edge. No done pulse; result and flags keep their previous values.
  - In IDLE: abort has priority over start, and start is dropped.
- result and flags change only on a completing write or on reset, never during CALC.
- Back-to-back: a start in the first IDLE cycle after DONE is accepted.

Optional Feature:
- Macro: EXEC_REMAINDER_EN.
- Defined:
  - Adds output port remainder (WIDTH).
  - Written with the final partial remainder on div completion.
  - Set to 0 on add/sub/mul completion; set to operand_a on divide-by-zero.
  - Reset value 0; held like result.
- Undefined: port absent and remainder register not synthesised. All other behaviour is identical.

Test Plan:
- WIDTH=16, add 1234+4321 -> result=5555, err_ovf=0, done high 1 cycle after start edge, busy high for exactly 1 cycle.
- sub 5-7 -> result=0xFFFE, err_ovf=1; then add 0xFFFF+1 -> result=0x0000, err_ovf=1.
- mul 300*200 -> result=60000 (0xEA60), err_ovf=0, done 17 cycles after start. Then mul 300*300 -> result=0x5F90, err_ovf=1.
- div 1000/7 -> result=142, remainder=6 (EXEC_REMAINDER_EN), done at 17 cycles. Then div 9/0 -> result=0xFFFF, err_div0=1, done after 1 cycle.
- Previous result=5555; mul 50*50 started, start pulsed at cycle 3 (ignored), abort at cycle 5 -> busy=0 next cycle, no done, result stays 5555. A new start is then accepted normally.
- Async reset asserted mid-division (cycle 8), between clock edges -> result, busy, done and flags read 0 immediately. After release, IDLE accepts start.

Source files
------------

// File: rtl/exec_sequencer.sv
// Multi-cycle calculator execute engine: single-cycle add/sub, shift-add multiply, restoring divide.
// Optional EXEC_REMAINDER_EN adds a registered remainder output.
module exec_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             err_ovf,
`ifdef EXEC_REMAINDER_EN
    output logic [WIDTH-1:0] remainder,
`endif
    output logic             err_div0
);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [ACC_W-1:0]   acc, acc_n;
    logic [WIDTH-1:0]   opb, opb_n;
    logic               is_div, is_div_n;
    logic               wr;
    logic [WIDTH-1:0]   result_n;
    logic               ovf_n, div0_n;
`ifdef EXEC_REMAINDER_EN
    logic [WIDTH-1:0]   rem_n;
`endif

    logic               accept;
    logic               iterative;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     mul_sum;
    logic [ACC_W-1:0]   mul_acc;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [ACC_W-1:0]   div_acc;

    assign accept    = (state == IDLE) && start && !abort;
    assign iterative = (op == OP_MUL) || ((op == OP_DIV) && (operand_b != '0));
    assign add_sum   = {1'b0, operand_a} + {1'b0, operand_b};

    // acc holds {partial product, multiplier} for mul and {partial remainder, quotient} for div
    assign mul_sum   = {1'b0, acc[ACC_W-1:WIDTH]} + (acc[0] ? {1'b0, opb} : (WIDTH+1)'(0));
    assign mul_acc   = {mul_sum, acc[WIDTH-1:1]};
    assign div_shift = {acc[ACC_W-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb};
    assign div_acc   = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = iterative ? CALC : DONE;
            CALC:    if (abort) state_n = IDLE;
                     else if (cnt == CNT_W'(1)) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath next values and result write strobe
    always_comb begin
        cnt_n    = cnt;
        acc_n    = acc;
        opb_n    = opb;
        is_div_n = is_div;
        wr       = 1'b0;
        result_n = result;
        ovf_n    = err_ovf;
        div0_n   = err_div0;
`ifdef EXEC_REMAINDER_EN
        rem_n    = remainder;
`endif
        if (accept) begin
            opb_n    = operand_b;
            is_div_n = (op == OP_DIV);
            if (iterative) begin
                acc_n = {WIDTH'(0), operand_a};
                cnt_n = CNT_W'(WIDTH);
            end else begin
                wr     = 1'b1;
                div0_n = 1'b0;
                ovf_n  = 1'b0;
`ifdef EXEC_REMAINDER_EN
                rem_n  = '0;
`endif
                case (op)
                    OP_ADD: begin
                        result_n = add_sum[WIDTH-1:0];
                        ovf_n    = add_sum[WIDTH];
                    end
                    OP_SUB: begin
                        result_n = operand_a - operand_b;
                        ovf_n    = (operand_a < operand_b);
                    end
                    default: begin
                        result_n = '1;
                        div0_n   = 1'b1;
`ifdef EXEC_REMAINDER_EN
                        rem_n    = operand_a;
`endif
                    end
                endcase
            end
        end else if ((state == CALC) && !abort) begin
            acc_n = is_div ? div_acc : mul_acc;
            cnt_n = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                wr     = 1'b1;
                div0_n = 1'b0;
                if (is_div) begin
                    result_n = div_acc[WIDTH-1:0];
                    ovf_n    = 1'b0;
`ifdef EXEC_REMAINDER_EN
                    rem_n    = div_acc[ACC_W-1:WIDTH];
`endif
                end else begin
                    result_n = mul_acc[WIDTH-1:0];
                    ovf_n    = |mul_acc[ACC_W-1:WIDTH];
`ifdef EXEC_REMAINDER_EN
                    rem_n    = '0;
`endif
                end
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            is_div   <= 1'b0;
            result   <= '0;
            err_ovf  <= 1'b0;
            err_div0 <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef EXEC_REMAINDER_EN
            remainder <= '0;
`endif
        end else begin
            cnt    <= cnt_n;
            acc    <= acc_n;
            opb    <= opb_n;
            is_div <= is_div_n;
            busy   <= (state_n != IDLE);
            done   <= (state_n == DONE);
            if (wr) begin
                result   <= result_n;
                err_ovf  <= ovf_n;
                err_div0 <= div0_n;
`ifdef EXEC_REMAINDER_EN
                remainder <= rem_n;
`endif
            end
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer (WIDTH=16); checks remainder when EXEC_REMAINDER_EN is defined.
module tb_exec_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [15:0] operand_a = '0;
    logic [15:0] operand_b = '0;
    logic [15:0] result;
    logic        busy, done, err_ovf, err_div0;
`ifdef EXEC_REMAINDER_EN
    logic [15:0] remainder;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int lat;
    logic seen_done;

    exec_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result    (result),
        .busy      (busy),
        .done      (done),
        .err_ovf   (err_ovf),
`ifdef EXEC_REMAINDER_EN
        .remainder (remainder),
`endif
        .err_div0  (err_div0)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one operation from IDLE and wait (bounded) for done; lat counts edges from the accept edge
    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          output int latency);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        latency = 1;
        while (!done && latency < 40) begin
            tick();
            latency++;
        end
    endtask

    initial begin
        #12;
        check("reset_result", 32'(result), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_flags", 32'({err_ovf, err_div0}), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // add: single-cycle, busy for exactly one cycle
        run_op(2'd0, 16'd1234, 16'd4321, lat);
        check("add_lat", 32'(lat), 32'd1);
        check("add_result", 32'(result), 32'd5555);
        check("add_ovf", 32'(err_ovf), 32'h0);
        check("add_busy", 32'(busy), 32'h1);
        tick();
        check("add_busy_after", 32'(busy), 32'h0);
        check("add_done_after", 32'(done), 32'h0);

        run_op(2'd1, 16'd5, 16'd7, lat);
        check("sub_result", 32'(result), 32'hFFFE);
        check("sub_ovf", 32'(err_ovf), 32'h1);
        tick();

        run_op(2'd0, 16'hFFFF, 16'd1, lat);
        check("add_wrap_result", 32'(result), 32'h0);
        check("add_wrap_ovf", 32'(err_ovf), 32'h1);
        tick();

        run_op(2'd2, 16'd300, 16'd200, lat);
        check("mul_lat", 32'(lat), 32'd17);
        check("mul_result", 32'(result), 32'hEA60);
        check("mul_ovf", 32'(err_ovf), 32'h0);
        tick();

        run_op(2'd2, 16'd300, 16'd300, lat);
        check("mul_ovf_result", 32'(result), 32'h5F90);
        check("mul_ovf_flag", 32'(err_ovf), 32'h1);
        tick();

        run_op(2'd3, 16'd1000, 16'd7, lat);
        check("div_lat", 32'(lat), 32'd17);
        check("div_result", 32'(result), 32'd142);
        check("div_flags", 32'({err_ovf, err_div0}), 32'h0);
`ifdef EXEC_REMAINDER_EN
        check("div_rem", 32'(remainder), 32'd6);
`endif
        tick();

        run_op(2'd3, 16'd9, 16'd0, lat);
        check("div0_lat", 32'(lat), 32'd1);
        check("div0_result", 32'(result), 32'hFFFF);
        check("div0_flags", 32'({err_ovf, err_div0}), 32'h1);
`ifdef EXEC_REMAINDER_EN
        check("div0_rem", 32'(remainder), 32'd9);
`endif
        // start while in DONE is dropped, not queued
        op = 2'd0; operand_a = 16'd1; operand_b = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("done_start_ignored", 32'(busy), 32'h0);
        tick();
        check("done_start_not_queued", 32'({busy, result}), 32'h0FFFF);

        // back-to-back start straight from a fresh result
        run_op(2'd0, 16'd1234, 16'd4321, lat);
        check("b2b_setup", 32'(result), 32'd5555);
        run_op(2'd0, 16'd1, 16'd2, lat);
        check("b2b_ignored_in_done", 32'(busy), 32'h0);
        tick();

        // abort has priority over start in IDLE
        run_op(2'd0, 16'd1234, 16'd4321, lat);
        tick();
        op = 2'd2; operand_a = 16'd50; operand_b = 16'd50; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 32'h0);

        // abort mid-multiply: no done, result kept
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("calc_busy", 32'(busy), 32'h1);
        check("calc_result_held", 32'(result), 32'd5555);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_result", 32'(result), 32'd5555);
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) seen_done = 1'b1;
            tick();
        end
        check("abort_no_done", 32'(seen_done), 32'h0);
        run_op(2'd2, 16'd50, 16'd50, lat);
        check("post_abort_lat", 32'(lat), 32'd17);
        check("post_abort_result", 32'(result), 32'd2500);
        tick();

        // async reset mid-division, between clock edges
        op = 2'd3; operand_a = 16'd1000; operand_b = 16'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        #2 reset = 1'b1;
        #1;
        check("areset_result", 32'(result), 32'h0);
        check("areset_busy_done", 32'({busy, done}), 32'h0);
        check("areset_flags", 32'({err_ovf, err_div0}), 32'h0);
        reset = 1'b0;
        tick();
        check("areset_idle", 32'(busy), 32'h0);
        run_op(2'd3, 16'd1000, 16'd7, lat);
        check("post_reset_lat", 32'(lat), 32'd17);
        check("post_reset_result", 32'(result), 32'd142);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
